flappy_scene_gen: RTL and testbench
===================================

// Module: flappy_scene_gen
// PURPOSE
// - Pixel source for the VGA controller: turns the controller's row_addr/col_addr/rdn into the 12-bit pixel d_in (bbbb_gggg_rrrr).
// - Holds Flappy Bird game state and updates it once per frame during vertical blank: bird physics, two scrolling pipes, collision, score.
// - Sits directly upstream of the VGA controller on vga_clk, in the same design.
// PARAMETERS
// - BIRD_X      160  bird left column (px); bird is a square
// - BIRD_SIZE   16   bird edge length (px)
// - GRAVITY     1    velocity increment per frame (px/frame)
// - FLAP_VEL    -8   velocity loaded on flap (signed)
// - MAX_FALL    8    downward velocity clamp (px/frame)
// - PIPE_W      48   pipe width (px)
// - GAP_H       128  vertical gap height (px)
// - PIPE_SPEED  2    leftward scroll per frame (px)
// PORTS
// - vga_clk    in   1   25 MHz pixel clock, the controller's clock
// - clrn       in   1   reset, asynchronous, active-low
// - row_addr   in   9   current pixel row, 0-479 visible
// - col_addr   in   10  current pixel column, 0-639 visible
// - rdn        in   1   pixel read strobe, active-low
// - flap       in   1   debounced button, asynchronous to vga_clk
// - d_in       out  12  pixel colour, bbbb_gggg_rrrr
// - score      out  8   pipes passed, saturates at 255
// - game_over  out  1   high in state DEAD
// BEHAVIOUR
// - Reset values: state IDLE; bird_y=232; vel=0; pipe_x={640,960}; gap_top={176,176}; lfsr=8'hA5; score=0; game_over=0; hit=0; flap_pend=0.
// - d_in is combinational from row_addr/col_addr and registered state (0-cycle latency). The controller samples it one cycle after presenting the address.
// - Colour priority: rdn=1 -> 12'h000; bird -> 12'h0FF; pipe -> 12'h0C0; sky -> 12'hFC7.
//   - Bird: col in [BIRD_X, BIRD_X+BIRD_SIZE), row in [bird_y, bird_y+BIRD_SIZE).
//   - Pipe i: col in [pipe_x, pipe_x+PIPE_W) and row outside [gap_top, gap_top+GAP_H).
// - flap: 2-flop synchroniser, then rising-edge detect, which sets flap_pend. flap_pend is consumed only at frame_tick.
// - frame_tick: one-cycle registered pulse on the first cycle with row_addr==480 && col_addr==0 (once per frame, in vertical blank).
// - Signed widths: pipe_x is 11-bit signed, bird_y is 11-bit signed, vel is 8-bit signed. Pixel compares use zero-extended addresses.
// - hit: set on any cycle with rdn=0 where the bird pixel and a pipe pixel overlap. Cleared at frame_tick after being evaluated.
// - FSM, evaluated only at frame_tick:
//   - IDLE: bird and pipes frozen. If flap_pend: go to PLAY, vel=FLAP_VEL, score=0, pipes reloaded to reset values.
//   - PLAY: if hit, or bird_y+vel<0, or bird_y+vel+BIRD_SIZE>480: go to DEAD with positions frozen. Otherwise:
//     - vel = flap_pend ? FLAP_VEL : min(vel+GRAVITY, MAX_FALL); bird_y += new vel.
//     - Each pipe: pipe_x -= PIPE_SPEED. If result <= -PIPE_W: pipe_x += 640+PIPE_W, gap_top = 64+lfsr, lfsr steps.
//     - Score: +1 per pipe whose right edge crosses from >=BIRD_X to <BIRD_X. Both pipes crossing in one frame adds 2. Saturates at 255.
//   - DEAD: game_over=1; everything frozen. If flap_pend: go to IDLE, bird_y=232, vel=0; score holds until the next PLAY entry.
// - flap_pend clears at every frame_tick. A flap edge arriving in the same cycle as frame_tick is kept for the next frame.
// - lfsr: 8-bit, taps x^8+x^6+x^5+x^4+1. Steps only on a pipe respawn, so gap_top always lies in 64..319.
// - clrn asserted mid-frame or mid-game: all state returns immediately to reset values; d_in then shows the reset scene.
// CONFIGURATION
// - FLAPPY_INVINCIBLE_EN defined: pipe overlap never sets hit; the floor/ceiling checks clamp bird_y to [0, 480-BIRD_SIZE] with vel=0, so DEAD is never entered.
// - FLAPPY_INVINCIBLE_EN undefined: full collision behaviour as above (default).
// TESTING
// - Reset, drive row 100/col 100, rdn=0 -> d_in=12'hFC7; row 240/col 165 -> 12'h0FF; rdn=1 -> 12'h000.
// - IDLE, flap pulse, one frame_tick -> state PLAY, vel=-8, bird_y=224; with no further flaps vel steps +1 per frame and stops at 8.
// - PLAY with pipe0 at x=112, 5 frames -> pipe0 right edge goes from 160 to 150 (crossing BIRD_X=160) -> score increments by exactly 1.
// - Force pipe0 to x=-46 -> next tick pipe_x=642, gap_top=64+lfsr (lfsr=8'hA5 first), lfsr advances.
// - Scan an overlapping bird/pipe pixel -> hit=1 -> next frame_tick game_over=1; pipes and bird frozen; a flap then returns to IDLE with bird_y=232.
// - Free-fall to the floor -> DEAD in the frame where bird_y+vel+16>480; with FLAPPY_INVINCIBLE_EN, bird_y clamps to 464 and game_over stays 0.

Source files
------------

// File: rtl/flappy_scene_gen.sv
// ============================================================================
// Module : flappy_scene_gen
// Flappy Bird pixel source and per-frame game engine for the VGA controller.
// Build option: define FLAPPY_INVINCIBLE_EN to disable deaths (bird clamps).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module flappy_scene_gen #(
    parameter int BIRD_X     = 160,
    parameter int BIRD_SIZE  = 16,
    parameter int GRAVITY    = 1,
    parameter int FLAP_VEL   = -8,
    parameter int MAX_FALL   = 8,
    parameter int PIPE_W     = 48,
    parameter int GAP_H      = 128,
    parameter int PIPE_SPEED = 2
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    input  logic        flap,
    output logic [11:0] d_in,
    output logic [7:0]  score,
    output logic        game_over
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam logic signed [10:0] c_y_reset     = 11'sd232;
    localparam logic signed [10:0] c_y_max       = 11'(480 - BIRD_SIZE);
    localparam logic signed [10:0] c_px0_reset   = 11'sd640;
    localparam logic signed [10:0] c_px1_reset   = 11'sd960;
    localparam logic        [8:0]  c_gap_reset   = 9'd176;
    localparam logic        [8:0]  c_gap_base    = 9'd64;
    localparam logic        [7:0]  c_lfsr_reset  = 8'hA5;
    localparam logic signed [7:0]  c_vel_flap    = 8'(FLAP_VEL);
    localparam logic signed [7:0]  c_vel_max     = 8'(MAX_FALL);
    localparam logic signed [7:0]  c_grav        = 8'(GRAVITY);
    localparam logic signed [10:0] c_speed       = 11'(PIPE_SPEED);
    localparam logic signed [10:0] c_respawn_lim = 11'(-PIPE_W);
    localparam logic signed [10:0] c_respawn_add = 11'(640 + PIPE_W);
    localparam logic signed [10:0] c_cross_lim   = 11'(BIRD_X - PIPE_W);
    localparam logic signed [10:0] c_bird_x      = 11'(BIRD_X);
    localparam logic signed [10:0] c_bird_sz     = 11'(BIRD_SIZE);
    localparam logic signed [10:0] c_pipe_w      = 11'(PIPE_W);
    localparam logic        [9:0]  c_gap_h       = 10'(GAP_H);

    function automatic logic signed [10:0] f_sext(input logic signed [7:0] v);
        return {{3{v[7]}}, v};
    endfunction

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting left
    function automatic logic [7:0] f_lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    state_t                r_state;
    logic signed [10:0]    r_bird_y;
    logic signed [7:0]     r_vel;
    logic signed [10:0]    r_pipe_x [2];
    logic        [8:0]     r_gap_top [2];
    logic        [7:0]     r_lfsr;
    logic        [7:0]     r_score;
    logic                  r_hit;
    logic                  r_flap_pend;
    logic                  r_flap_s1;
    logic                  r_flap_s2;
    logic                  r_flap_d;
    logic                  r_at_d;
    logic                  r_frame_tick;

    state_t                w_state_nx;
    logic signed [10:0]    w_y_nx;
    logic signed [7:0]     w_vel_nx;
    logic signed [10:0]    w_px_nx [2];
    logic        [8:0]     w_gap_nx [2];
    logic        [7:0]     w_lfsr_nx;
    logic        [7:0]     w_score_nx;
    logic signed [10:0]    w_y_try;
    logic signed [7:0]     w_vel_new;
    logic signed [10:0]    w_px_dec;
    logic        [1:0]     w_cross;
    logic        [8:0]     w_score_sum;
    logic                  w_bird_out;
    logic                  w_alive;

    logic signed [10:0]    w_row_s;
    logic signed [10:0]    w_col_s;
    logic        [9:0]     w_row_u;
    logic                  w_bird_pix;
    logic        [1:0]     w_pipe_pix;
    logic                  w_hit_set;
    logic                  w_at;
    logic                  w_flap_rise;

    // ------------------------------------------------------------------
    // Pixel generation
    // ------------------------------------------------------------------
    assign w_row_s = $signed({2'b00, row_addr});
    assign w_col_s = $signed({1'b0, col_addr});
    assign w_row_u = {1'b0, row_addr};

    assign w_bird_pix = (w_col_s >= c_bird_x) && (w_col_s < c_bird_x + c_bird_sz) &&
                        (w_row_s >= r_bird_y) && (w_row_s < r_bird_y + c_bird_sz);

    for (genvar gi = 0; gi < 2; gi++) begin : g_pipe
        assign w_pipe_pix[gi] = (w_col_s >= r_pipe_x[gi]) &&
                                (w_col_s < r_pipe_x[gi] + c_pipe_w) &&
                                ((w_row_u < {1'b0, r_gap_top[gi]}) ||
                                 (w_row_u >= {1'b0, r_gap_top[gi]} + c_gap_h));
    end

    always_comb begin
        d_in = 12'hFC7;
        if (rdn)
            d_in = 12'h000;
        else if (w_bird_pix)
            d_in = 12'h0FF;
        else if (|w_pipe_pix)
            d_in = 12'h0C0;
    end

`ifdef FLAPPY_INVINCIBLE_EN
    assign w_hit_set = 1'b0;
`else
    assign w_hit_set = ~rdn & w_bird_pix & (|w_pipe_pix);
`endif

    // ------------------------------------------------------------------
    // Flap synchroniser, frame tick, pending flap and hit flags
    // ------------------------------------------------------------------
    assign w_at        = (row_addr == 9'd480) && (col_addr == 10'd0);
    assign w_flap_rise = r_flap_s2 & ~r_flap_d;

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_flap_s1    <= 1'b0;
            r_flap_s2    <= 1'b0;
            r_flap_d     <= 1'b0;
            r_at_d       <= 1'b0;
            r_frame_tick <= 1'b0;
            r_flap_pend  <= 1'b0;
            r_hit        <= 1'b0;
        end else begin
            r_flap_s1    <= flap;
            r_flap_s2    <= r_flap_s1;
            r_flap_d     <= r_flap_s2;
            r_at_d       <= w_at;
            r_frame_tick <= w_at & ~r_at_d;
            // an edge coinciding with the tick survives into the next frame
            if (r_frame_tick)
                r_flap_pend <= w_flap_rise;
            else if (w_flap_rise)
                r_flap_pend <= 1'b1;
            if (r_frame_tick)
                r_hit <= 1'b0;
            else if (w_hit_set)
                r_hit <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Game state machine, advanced once per frame tick
    // ------------------------------------------------------------------
    assign w_y_try    = r_bird_y + f_sext(r_vel);
    assign w_bird_out = w_y_try[10] || (w_y_try > c_y_max);
    assign w_vel_new  = r_flap_pend ? c_vel_flap :
                        ((r_vel >= c_vel_max) ? c_vel_max : r_vel + c_grav);

    always_comb begin
        w_state_nx  = r_state;
        w_y_nx      = r_bird_y;
        w_vel_nx    = r_vel;
        w_px_nx     = r_pipe_x;
        w_gap_nx    = r_gap_top;
        w_lfsr_nx   = r_lfsr;
        w_score_nx  = r_score;
        w_px_dec    = '0;
        w_cross     = '0;
        w_score_sum = '0;
        w_alive     = 1'b0;
        if (r_frame_tick) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (r_flap_pend) begin
                        w_state_nx = ST_PLAY;
                        w_vel_nx   = c_vel_flap;
                        w_y_nx     = r_bird_y + f_sext(c_vel_flap);
                        w_score_nx = '0;
                        w_px_nx[0] = c_px0_reset;
                        w_px_nx[1] = c_px1_reset;
                        w_gap_nx[0] = c_gap_reset;
                        w_gap_nx[1] = c_gap_reset;
                    end
                end
                ST_PLAY: begin
`ifdef FLAPPY_INVINCIBLE_EN
                    w_alive = ~r_hit;
                    if (w_y_try[10]) begin
                        w_y_nx   = '0;
                        w_vel_nx = '0;
                    end else if (w_y_try > c_y_max) begin
                        w_y_nx   = c_y_max;
                        w_vel_nx = '0;
                    end else begin
                        w_vel_nx = w_vel_new;
                        w_y_nx   = r_bird_y + f_sext(w_vel_new);
                    end
`else
                    w_alive = ~(r_hit | w_bird_out);
                    if (w_alive) begin
                        w_vel_nx = w_vel_new;
                        w_y_nx   = r_bird_y + f_sext(w_vel_new);
                    end else begin
                        w_state_nx = ST_DEAD;
                    end
`endif
                    if (w_alive) begin
                        for (int i = 0; i < 2; i++) begin
                            w_px_dec = r_pipe_x[i] - c_speed;
                            if (w_px_dec <= c_respawn_lim) begin
                                w_px_nx[i]  = r_pipe_x[i] + c_respawn_add;
                                w_gap_nx[i] = c_gap_base + {1'b0, w_lfsr_nx};
                                w_lfsr_nx   = f_lfsr_step(w_lfsr_nx);
                            end else begin
                                w_px_nx[i] = w_px_dec;
                                if ((r_pipe_x[i] >= c_cross_lim) && (w_px_dec < c_cross_lim))
                                    w_cross = w_cross + 2'd1;
                            end
                        end
                        w_score_sum = {1'b0, r_score} + {7'd0, w_cross};
                        w_score_nx  = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
                    end
                end
                ST_DEAD: begin
                    if (r_flap_pend) begin
                        w_state_nx = ST_IDLE;
                        w_y_nx     = c_y_reset;
                        w_vel_nx   = '0;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_state      <= ST_IDLE;
            r_bird_y     <= c_y_reset;
            r_vel        <= '0;
            r_pipe_x[0]  <= c_px0_reset;
            r_pipe_x[1]  <= c_px1_reset;
            r_gap_top[0] <= c_gap_reset;
            r_gap_top[1] <= c_gap_reset;
            r_lfsr       <= c_lfsr_reset;
            r_score      <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_bird_y     <= w_y_nx;
            r_vel        <= w_vel_nx;
            r_pipe_x     <= w_px_nx;
            r_gap_top    <= w_gap_nx;
            r_lfsr       <= w_lfsr_nx;
            r_score      <= w_score_nx;
        end
    end

    assign score     = r_score;
    assign game_over = (r_state == ST_DEAD);

endmodule

`default_nettype wire

// File: tb/tb_flappy_scene_gen.sv
// ============================================================================
// Module : tb_flappy_scene_gen
// Self-checking bench for flappy_scene_gen (default build).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flappy_scene_gen;

    logic        vga_clk = 1'b0;
    logic        clrn;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        rdn;
    logic        flap;
    logic [11:0] d_in;
    logic [7:0]  score;
    logic        game_over;

    always #20 vga_clk = ~vga_clk;

    flappy_scene_gen dut (
        .vga_clk   (vga_clk),
        .clrn      (clrn),
        .row_addr  (row_addr),
        .col_addr  (col_addr),
        .rdn       (rdn),
        .flap      (flap),
        .d_in      (d_in),
        .score     (score),
        .game_over (game_over)
    );

    int n_total = 0;
    int n_bad   = 0;

    // reference game model (0 IDLE, 1 PLAY, 2 DEAD)
    int         m_state, m_y, m_v, m_score;
    int         m_px [2];
    int         m_g  [2];
    logic [7:0] m_lfsr;
    bit         m_pend, m_hit;

    typedef struct {
        logic        rdn;
        int          row;
        int          col;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_y = 232; m_v = 0; m_score = 0;
        m_px[0] = 640; m_px[1] = 960; m_g[0] = 176; m_g[1] = 176;
        m_lfsr = 8'hA5; m_pend = 0; m_hit = 0;
    endtask

    task automatic model_tick();
        int ty, nv, n;
        case (m_state)
            0: if (m_pend) begin
                m_state = 1; m_v = -8; m_y = m_y - 8; m_score = 0;
                m_px[0] = 640; m_px[1] = 960; m_g[0] = 176; m_g[1] = 176;
            end
            1: begin
                ty = m_y + m_v;
                if (m_hit || ty < 0 || ty + 16 > 480) begin
                    m_state = 2;
                end else begin
                    nv = m_pend ? -8 : ((m_v + 1 > 8) ? 8 : m_v + 1);
                    m_v = nv;
                    m_y = m_y + nv;
                    for (int i = 0; i < 2; i++) begin
                        n = m_px[i] - 2;
                        if (n <= -48) begin
                            m_px[i] = m_px[i] + 688;
                            m_g[i]  = 64 + int'(m_lfsr);
                            m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
                        end else begin
                            if (m_px[i] + 48 >= 160 && n + 48 < 160) m_score++;
                            m_px[i] = n;
                        end
                    end
                    if (m_score > 255) m_score = 255;
                end
            end
            default: if (m_pend) begin
                m_state = 0; m_y = 232; m_v = 0;
            end
        endcase
        m_pend = 0;
        m_hit  = 0;
    endtask

    function automatic logic [11:0] exp_pix(input logic rd, input int row, input int col);
        bit pipe = 0;
        if (rd) return 12'h000;
        if (col >= 160 && col < 176 && row >= m_y && row < m_y + 16) return 12'h0FF;
        for (int i = 0; i < 2; i++)
            if (col >= m_px[i] && col < m_px[i] + 48 && (row < m_g[i] || row >= m_g[i] + 128))
                pipe = 1;
        return pipe ? 12'h0C0 : 12'hFC7;
    endfunction

    task automatic probe(input string nm, input logic rd, input int row, input int col,
                         input logic [11:0] exp);
        @(negedge vga_clk);
        rdn = rd; row_addr = 9'(row); col_addr = 10'(col);
        #1 chk(nm, d_in, exp);
        #2 rdn = 1'b1;
    endtask

    task automatic flap_pulse();
        @(negedge vga_clk) flap = 1'b1;
        repeat (4) @(negedge vga_clk);
        flap = 1'b0;
        repeat (4) @(negedge vga_clk);
    endtask

    task automatic tick();
        @(negedge vga_clk);
        rdn = 1'b1; row_addr = 9'd480; col_addr = 10'd0;
        @(negedge vga_clk);
        row_addr = 9'd0;
        @(negedge vga_clk);
    endtask

    task automatic do_frame(input bit f);
        if (f) begin
            flap_pulse();
            m_pend = 1;
        end
        tick();
        model_tick();
        chk("game_over", {11'd0, game_over}, {11'd0, m_state == 2});
        chk("score", {4'd0, score}, 12'(m_score));
        if (m_y >= 1 && m_y <= 479) begin
            probe("bird_top", 1'b0, m_y, 165, exp_pix(1'b0, m_y, 165));
            probe("bird_above", 1'b0, m_y - 1, 165, exp_pix(1'b0, m_y - 1, 165));
        end
    endtask

    initial begin
        int k;
        vecs[0] = '{1'b0, 100, 100, 12'hFC7};
        vecs[1] = '{1'b0, 240, 165, 12'h0FF};
        vecs[2] = '{1'b1, 240, 165, 12'h000};
        vecs[3] = '{1'b0, 232, 160, 12'h0FF};
        vecs[4] = '{1'b0, 247, 175, 12'h0FF};
        vecs[5] = '{1'b0, 231, 165, 12'hFC7};
        vecs[6] = '{1'b0, 248, 165, 12'hFC7};
        vecs[7] = '{1'b0, 240, 159, 12'hFC7};
        vecs[8] = '{1'b0, 240, 176, 12'hFC7};
        vecs[9] = '{1'b0, 479, 639, 12'hFC7};

        clrn = 1'b0; rdn = 1'b1; flap = 1'b0; row_addr = '0; col_addr = '0;
        model_reset();
        repeat (3) @(negedge vga_clk);
        clrn = 1'b1;

        for (int i = 0; i < 10; i++)
            probe($sformatf("reset_vec%0d", i), vecs[i].rdn, vecs[i].row, vecs[i].col, vecs[i].exp);
        chk("reset_score", {4'd0, score}, 12'd0);
        chk("reset_game_over", {11'd0, game_over}, 12'd0);

        // start: first frame lifts the bird by 8
        do_frame(1'b1);
        probe("entry_y", 1'b0, 224, 160, 12'h0FF);
        probe("entry_above", 1'b0, 223, 160, 12'hFC7);
        repeat (16) do_frame(1'b0);
        probe("fall_232", 1'b0, 232, 165, 12'h0FF);
        probe("fall_231", 1'b0, 231, 165, 12'hFC7);
        do_frame(1'b0);
        probe("clamp_240", 1'b0, 240, 165, 12'h0FF);
        probe("clamp_239", 1'b0, 239, 165, 12'hFC7);

        // fly until pipe0 sits at x=112, then cross the bird column
        k = 0;
        while (m_px[0] != 112 && k < 400) begin do_frame(m_y >= 240); k++; end
        chk("reach_112", {11'd0, m_px[0] == 112}, 12'd1);
        chk("score_before", {4'd0, score}, 12'd0);
        repeat (5) do_frame(m_y >= 240);
        chk("score_cross", {4'd0, score}, 12'd1);

        // pipe0 respawn from x=-46: lands at 642 with gap_top 64+0xA5=229
        k = 0;
        while (m_px[0] != -46 && k < 200) begin do_frame(m_y >= 240); k++; end
        chk("reach_m46", {11'd0, m_px[0] == -46}, 12'd1);
        repeat (3) do_frame(m_y >= 240);
        probe("respawn_top", 1'b0, 228, 639, 12'h0C0);
        probe("respawn_gap_top", 1'b0, 229, 639, 12'hFC7);
        probe("respawn_gap_bot", 1'b0, 356, 639, 12'hFC7);
        probe("respawn_bot", 1'b0, 357, 639, 12'h0C0);
        probe("respawn_left", 1'b0, 228, 637, 12'hFC7);

        // climb above pipe1's gap and scan an overlap pixel
        k = 0;
        while (m_px[1] > 170 && k < 200) begin do_frame(m_y >= 100); k++; end
        chk("reach_170", {11'd0, m_px[1] == 170}, 12'd1);
        @(negedge vga_clk);
        rdn = 1'b0; row_addr = 9'(m_y); col_addr = 10'd170;
        @(posedge vga_clk);
        #1 chk("hit_pixel", d_in, 12'h0FF);
        m_hit = 1;
        @(negedge vga_clk) rdn = 1'b1;
        do_frame(1'b0);
        chk("hit_dead", {11'd0, game_over}, 12'd1);
        do_frame(1'b0);
        chk("dead_hold", {11'd0, game_over}, 12'd1);
        probe("frozen_pipe", 1'b0, 100, 217, 12'h0C0);
        probe("frozen_pipe_edge", 1'b0, 100, 218, 12'hFC7);
        do_frame(1'b1);
        chk("restart_idle", {11'd0, game_over}, 12'd0);
        chk("score_held", {4'd0, score}, 12'd1);
        probe("idle_bird", 1'b0, 232, 165, 12'h0FF);

        // asynchronous reset mid-game
        @(negedge vga_clk);
        rdn = 1'b0; row_addr = 9'd240; col_addr = 10'd165;
        #5 clrn = 1'b0;
        #1;
        chk("async_score", {4'd0, score}, 12'd0);
        chk("async_game_over", {11'd0, game_over}, 12'd0);
        chk("async_pixel", d_in, 12'h0FF);
        rdn = 1'b1;
        model_reset();
        repeat (2) @(negedge vga_clk);
        clrn = 1'b1;

        // free fall into the floor: dies with bird_y frozen at 464
        do_frame(1'b1);
        k = 0;
        while (m_state != 2 && k < 100) begin do_frame(1'b0); k++; end
        chk("floor_dead", {11'd0, game_over}, 12'd1);
        probe("floor_y", 1'b0, 464, 165, 12'h0FF);
        probe("floor_above", 1'b0, 463, 165, 12'hFC7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
